pc_control: RTL and testbench

Program-counter and fetch-sequencing stage. It consumes the ALU's branch decision (sinalBranch), together with the decoder's jump, halt and I/O-wait controls, and produces the instruction-memory address for the next cycle. It sits upstream of instruction fetch and downstream of the ALU. It also keeps a retired-instruction counter for debug.

---
 rtl/pc_control.sv | 116 +++++++++++
 tb/tb_pc_control.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Program counter and fetch sequencer: picks the next instruction address from
// branch/jump/halt/IO-wait controls and counts retired instructions (saturating).
module pc_control #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sinalBranch,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jumpTarget,
    input  logic                  jumpReg,
    input  logic [31:0]           regTarget,
    input  logic                  halt,
    input  logic                  restart,
    input  logic                  ioWait,
    input  logic                  ioReady,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcPlus1,
    output logic [1:0]            state,
    output logic [31:0]           retired
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10,
        ST_BAD  = 2'b11
    } st_e;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    st_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [31:0]           retired_q, retired_d;
    logic                  retire;

    // Natural ADDR_WIDTH truncation gives the modulo-2^ADDR_WIDTH wrap.
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= PC_INIT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        retire  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (ioWait && !ioReady) begin
                    state_d = ST_WAIT;
                end else if (ioWait) begin
                    pc_d   = pc_inc;
                    retire = 1'b1;
                end else if (sinalBranch) begin
                    pc_d   = branchTarget;
                    retire = 1'b1;
                end else if (jumpReg) begin
                    pc_d   = regTarget[ADDR_WIDTH-1:0];
                    retire = 1'b1;
                end else if (jump) begin
                    pc_d   = jumpTarget;
                    retire = 1'b1;
                end else begin
                    pc_d   = pc_inc;
                    retire = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ioReady && !stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                    retire  = 1'b1;
                end
            end
            ST_HALT: begin
                if (restart) begin
                    pc_d    = PC_INIT;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;  // unreachable encoding: recover with pc held
        endcase
    end

    // Saturating counter: stops at all-ones instead of wrapping.
    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != 32'hFFFF_FFFF))
            retired_d = retired_q + 32'd1;
    end

    always_comb begin
        pc      = pc_q;
        pcPlus1 = pc_inc;
        state   = state_q;
        retired = retired_q;
    end

endmodule

// File: tb/tb_pc_control.sv
// Directed table-driven bench for pc_control, plus hand sequences for
// input-to-output isolation and retired-counter saturation.
module tb_pc_control;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sinalBranch = 1'b0;
    logic [AW-1:0] branchTarget = '0;
    logic          jump = 1'b0;
    logic [AW-1:0] jumpTarget = '0;
    logic          jumpReg = 1'b0;
    logic [31:0]   regTarget = '0;
    logic          halt = 1'b0;
    logic          restart = 1'b0;
    logic          ioWait = 1'b0;
    logic          ioReady = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] pc;
    logic [AW-1:0] pcPlus1;
    logic [1:0]    state;
    logic [31:0]   retired;

    int n_vec = 0;
    int n_err = 0;

    pc_control #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset),
        .sinalBranch(sinalBranch), .branchTarget(branchTarget),
        .jump(jump), .jumpTarget(jumpTarget),
        .jumpReg(jumpReg), .regTarget(regTarget),
        .halt(halt), .restart(restart),
        .ioWait(ioWait), .ioReady(ioReady), .stall(stall),
        .pc(pc), .pcPlus1(pcPlus1), .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst, br;
        logic [AW-1:0] bt;
        logic          j;
        logic [AW-1:0] jt;
        logic          jr;
        logic [31:0]   rt;
        logic          h, rs, iw, ir, st;
        logic [AW-1:0] epc;
        logic [1:0]    est;
        logic [31:0]   eret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit br, input int bt, input bit j, input int jt,
                       input bit jr, input logic [31:0] rt, input bit h, input bit rs,
                       input bit iw, input bit ir, input bit st,
                       input int epc, input int est, input logic [31:0] eret);
        vec_t v;
        v.rst = rst; v.br = br; v.bt = AW'(bt); v.j = j; v.jt = AW'(jt);
        v.jr = jr; v.rt = rt; v.h = h; v.rs = rs; v.iw = iw; v.ir = ir; v.st = st;
        v.epc = AW'(epc); v.est = 2'(est); v.eret = eret;
        vecs.push_back(v);
    endtask

    task automatic idle(input int epc, input int est, input logic [31:0] eret);
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0,0, epc, est, eret);
    endtask

    task automatic check(input string name, input logic [AW-1:0] epc,
                         input logic [1:0] est, input logic [31:0] eret);
        logic [AW-1:0] ep1;
        ep1 = epc + AW'(1);
        n_vec++;
        if (pc !== epc) begin
            n_err++;
            $display("FAIL %s pc: got %0d want %0d", name, pc, epc);
        end
        if (pcPlus1 !== ep1) begin
            n_err++;
            $display("FAIL %s pcPlus1: got %0d want %0d", name, pcPlus1, ep1);
        end
        if (state !== est) begin
            n_err++;
            $display("FAIL %s state: got %b want %b", name, state, est);
        end
        if (retired !== eret) begin
            n_err++;
            $display("FAIL %s retired: got %h want %h", name, retired, eret);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; sinalBranch = v.br; branchTarget = v.bt; jump = v.j;
        jumpTarget = v.jt; jumpReg = v.jr; regTarget = v.rt; halt = v.h;
        restart = v.rs; ioWait = v.iw; ioReady = v.ir; stall = v.st;
    endtask

    initial begin
        vec_t z;
        //   rst br bt  j jt   jr rt            h rs iw ir st   pc  st ret
        add(1, 0,0,   0,0,   0,0,            0,0, 0,0,0,   0,  0, 0);
        for (int i = 1; i <= 7; i++) idle(i, 0, i);
        add(0, 1,40,  1,90,  0,0,            0,0, 0,0,0,   40, 0, 8);   // branch beats jump
        add(0, 0,0,   0,0,   1,32'hFFFF_F003, 0,0, 0,0,0,   3,  0, 9);   // upper regTarget bits dropped
        add(0, 0,0,   1,12,  0,0,            0,0, 0,0,0,   12, 0, 10);
        add(0, 0,0,   0,0,   0,0,            0,0, 1,0,0,   12, 1, 10);  // enter WAIT_IO
        add(0, 0,0,   0,0,   0,0,            0,0, 1,0,0,   12, 1, 10);
        add(0, 1,500, 1,300, 0,0,            1,0, 1,0,0,   12, 1, 10);  // branch/jump/halt ignored
        add(0, 0,0,   0,0,   0,0,            0,0, 0,1,0,   13, 0, 11);
        add(0, 0,0,   0,0,   0,0,            0,0, 1,1,0,   14, 0, 12);  // same-cycle ready
        add(0, 0,0,   0,0,   0,0,            0,0, 1,0,0,   14, 1, 12);
        add(0, 0,0,   0,0,   0,0,            0,0, 0,1,1,   14, 1, 12);  // stall wins over ready
        add(0, 0,0,   0,0,   0,0,            0,0, 0,1,0,   15, 0, 13);
        add(0, 0,0,   1,20,  0,0,            0,0, 0,0,0,   20, 0, 14);
        add(0, 1,0,   1,0,   0,0,            1,0, 0,0,0,   20, 2, 15);  // halt beats branch
        add(0, 1,100, 0,0,   0,0,            0,0, 0,0,0,   20, 2, 15);
        add(0, 0,0,   1,200, 0,0,            0,0, 0,0,0,   20, 2, 15);
        add(0, 1,100, 1,200, 1,7,            0,0, 0,0,0,   20, 2, 15);
        add(0, 0,0,   0,0,   0,0,            0,0, 1,1,0,   20, 2, 15);
        add(0, 0,0,   0,0,   0,0,            0,1, 0,0,0,   0,  0, 15);  // restart keeps retired
        add(0, 0,0,   1,1023,0,0,            0,0, 0,0,0,   1023,0,16);
        idle(0, 0, 17);                                                  // wrap 1023 -> 0
        add(0, 0,0,   0,0,   0,0,            0,0, 0,0,1,   0,  0, 17);
        add(0, 1,9,   0,0,   0,0,            1,0, 0,0,1,   0,  0, 17);  // stall beats halt/branch
        add(0, 0,0,   1,9,   1,5,            0,0, 0,0,0,   5,  0, 18);  // jumpReg beats jump
        add(0, 0,0,   0,0,   0,0,            1,0, 1,0,0,   5,  2, 19);  // halt beats ioWait
        add(1, 0,0,   0,0,   0,0,            0,0, 0,0,0,   0,  0, 0);   // reset from HALTED
        add(0, 0,0,   0,0,   0,0,            0,0, 1,0,0,   0,  1, 0);
        add(1, 0,0,   0,0,   0,0,            0,0, 0,1,0,   0,  0, 0);   // reset from WAIT_IO

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].est, vecs[i].eret);
        end

        // Inputs must not reach pc/state without a clock edge.
        @(negedge clock);
        z = vecs[0];
        z.rst = 0; z.j = 1; z.jt = AW'(77);
        drive(z);
        #2;
        check("comb_iso", 0, 0, 0);
        @(posedge clock);
        #1;
        check("jump77", 77, 0, 1);

        // Saturation of the retired counter.
        @(negedge clock);
        z.j = 0;
        drive(z);
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        #1;
        check("preload", 77, 0, 32'hFFFF_FFFE);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("sat%0d", i), AW'(77 + i), 0, 32'hFFFF_FFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
